// File: rtl/wb_stage_if.sv
// Bus between the M stage / pipeline control and the MEM/WB write-back stage.
// Carries RetireCnt only when WB_RETIRE_CNT_EN is defined.
interface wb_stage_if;
    logic        Stall;
    logic        Flush;
    logic        M_Valid;
    logic [31:0] M_PC4;
    logic        M_RegWE;
    logic [4:0]  M_A3;
    logic [1:0]  M_WBSel;
    logic [31:0] M_ALUOut;
    logic [31:0] M_MemRD;
    logic [2:0]  M_LoadType;

    logic        W_Valid;
    logic        WE;
    logic [4:0]  A3;
    logic [31:0] WD;
    logic [31:0] PC4;
    logic        W_AdEL;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] RetireCnt;

    modport master (
        output Stall, Flush, M_Valid, M_PC4, M_RegWE, M_A3, M_WBSel,
               M_ALUOut, M_MemRD, M_LoadType,
        input  W_Valid, WE, A3, WD, PC4, W_AdEL, RetireCnt
    );

    modport slave (
        input  Stall, Flush, M_Valid, M_PC4, M_RegWE, M_A3, M_WBSel,
               M_ALUOut, M_MemRD, M_LoadType,
        output W_Valid, WE, A3, WD, PC4, W_AdEL, RetireCnt
    );
`else
    modport master (
        output Stall, Flush, M_Valid, M_PC4, M_RegWE, M_A3, M_WBSel,
               M_ALUOut, M_MemRD, M_LoadType,
        input  W_Valid, WE, A3, WD, PC4, W_AdEL
    );

    modport slave (
        input  Stall, Flush, M_Valid, M_PC4, M_RegWE, M_A3, M_WBSel,
               M_ALUOut, M_MemRD, M_LoadType,
        output W_Valid, WE, A3, WD, PC4, W_AdEL
    );
`endif
endinterface

// File: rtl/wb_stage.sv
// MEM/WB pipeline register plus load extraction, write-back mux and misaligned-load detect.
// Optional retired-instruction counter enabled by WB_RETIRE_CNT_EN.
module wb_stage (
    input  logic       Clk,
    input  logic       Reset_n,
    wb_stage_if.slave  bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned REGW = 5;

    localparam logic [1:0] WB_MEM  = 2'b01;
    localparam logic [1:0] WB_LINK = 2'b10;

    localparam logic [2:0] LT_LB  = 3'b001;
    localparam logic [2:0] LT_LBU = 3'b010;
    localparam logic [2:0] LT_LH  = 3'b011;
    localparam logic [2:0] LT_LHU = 3'b100;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc4;
        logic            reg_we;
        logic [REGW-1:0] a3;
        logic [1:0]      wb_sel;
        logic [XLEN-1:0] alu_out;
        logic [XLEN-1:0] mem_rd;
        logic [2:0]      load_type;
    } mw_t;

    mw_t mw_q;
    mw_t m_in;

    always_comb begin
        m_in.valid     = bus.M_Valid;
        m_in.pc4       = bus.M_PC4;
        m_in.reg_we    = bus.M_RegWE;
        m_in.a3        = bus.M_A3;
        m_in.wb_sel    = bus.M_WBSel;
        m_in.alu_out   = bus.M_ALUOut;
        m_in.mem_rd    = bus.M_MemRD;
        m_in.load_type = bus.M_LoadType;
    end

    // Flush beats Stall; a flushed slot still captures the non-control fields.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mw_q <= '0;
        end else if (bus.Flush) begin
            mw_q        <= m_in;
            mw_q.valid  <= 1'b0;
            mw_q.reg_we <= 1'b0;
        end else if (!bus.Stall) begin
            mw_q <= m_in;
        end
    end

    logic [1:0]      off;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] load_val;
    logic            is_half;
    logic            is_word;

    always_comb begin
        off      = mw_q.alu_out[1:0];
        byte_sel = mw_q.mem_rd[7:0];
        case (off)
            2'd1:    byte_sel = mw_q.mem_rd[15:8];
            2'd2:    byte_sel = mw_q.mem_rd[23:16];
            2'd3:    byte_sel = mw_q.mem_rd[31:24];
            default: byte_sel = mw_q.mem_rd[7:0];
        endcase
        half_sel = off[1] ? mw_q.mem_rd[31:16] : mw_q.mem_rd[15:0];

        load_val = mw_q.mem_rd;
        case (mw_q.load_type)
            LT_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
            LT_LBU:  load_val = {24'b0, byte_sel};
            LT_LH:   load_val = {{16{half_sel[15]}}, half_sel};
            LT_LHU:  load_val = {16'b0, half_sel};
            default: load_val = mw_q.mem_rd;
        endcase
    end

    // Unknown load types behave as lw, including for alignment checking.
    always_comb begin
        is_half = (mw_q.load_type == LT_LH) || (mw_q.load_type == LT_LHU);
        is_word = !is_half && (mw_q.load_type != LT_LB) && (mw_q.load_type != LT_LBU);
    end

    logic            ad_el;
    logic [XLEN-1:0] wd;

    always_comb begin
        ad_el = mw_q.valid && (mw_q.wb_sel == WB_MEM) &&
                ((is_half && mw_q.alu_out[0]) || (is_word && (off != 2'b00)));

        wd = mw_q.alu_out;
        case (mw_q.wb_sel)
            WB_MEM:  wd = load_val;
            WB_LINK: wd = mw_q.pc4 + XLEN'(4);
            default: wd = mw_q.alu_out;
        endcase
    end

    assign bus.W_Valid = mw_q.valid;
    assign bus.W_AdEL  = ad_el;
    assign bus.WE      = mw_q.valid && mw_q.reg_we && (mw_q.a3 != '0) && !ad_el;
    assign bus.A3      = mw_q.a3;
    assign bus.WD      = wd;
    assign bus.PC4     = mw_q.pc4;

`ifdef WB_RETIRE_CNT_EN
    logic [XLEN-1:0] retire_cnt;

    // Counts each valid instruction once, on the edge it leaves W.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            retire_cnt <= '0;
        end else if (mw_q.valid && !bus.Stall) begin
            retire_cnt <= retire_cnt + XLEN'(1);
        end
    end

    assign bus.RetireCnt = retire_cnt;
`endif
endmodule
